// File: rtl/mii_pkg.sv
// Shared types and constants for the MII transmit path (framer and CRC helper).
// Reused by the receive-side checker for the CRC constants.
package mii_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_e;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

endpackage

// File: rtl/eth_crc32_nib.sv
// Combinational Ethernet CRC-32 step for one nibble, LSB-first (reflected) input.
// Returns the raw register; the caller complements it for the transmitted FCS.
module eth_crc32_nib
  import mii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {28'h0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: byte stream in, preamble/SFD/payload/FCS nibbles out, then IFG.
// Define MII_TX_PAD_EN to zero-pad short frames to MIN_PAYLOAD bytes before the FCS.
//
// state | meaning
// IDLE  | TXEN low, waiting for TX_VALID
// PRE   | preamble nibbles (4'h5)
// SFD   | start-of-frame nibble; first byte requested
// DATA  | payload byte, low nibble (phase 0) then high nibble (phase 1)
// PAD   | zero pad bytes (padding build only)
// FCS   | eight CRC nibbles, CRC[3:0] first
// IFG   | TXEN low, inter-frame gap
module mii_tx_framer
  import mii_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES      = 24,
  parameter int MIN_PAYLOAD      = 60
) (
  input  logic       RTL_TXCLK,
  input  logic       RESETB,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  input  logic       TX_LAST,
  output logic       TX_READY,
  output logic [3:0] RTL_TXD,
  output logic       RTL_TXEN,
  output logic       BUSY,
  output logic       TX_UNDERRUN
);

  localparam logic [7:0] PRE_LOAD = 8'(PREAMBLE_NIBBLES - 1);
  localparam logic [7:0] IFG_LOAD = 8'(IFG_NIBBLES - 1);
  localparam logic [7:0] FCS_LOAD = 8'd7;

  tx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        phase_q, phase_d;
  logic [31:0] crc_q, crc_d;
  logic        bad_q, bad_d;
  logic [3:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        underrun_q, underrun_d;

  logic        start_frame, take_byte, go_fcs, go_bad;
  logic [3:0]  feed_nib;
  logic [31:0] crc_next;
  logic [3:0]  fcs_nib;

`ifdef MII_TX_PAD_EN
  localparam logic [10:0] MIN_BYTES = 11'(MIN_PAYLOAD);
  logic [10:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
`else
  logic unused_min_payload;
  assign unused_min_payload = (MIN_PAYLOAD != 0);
`endif

  // Nibble that enters the CRC on this edge: the one being loaded into RTL_TXD.
  always_comb begin
    feed_nib = 4'h0;
    if (state_q == SFD || (state_q == DATA && phase_q && !last_q)) begin
      feed_nib = TX_DATA[3:0];
    end else if (state_q == DATA && !phase_q) begin
      feed_nib = byte_q[7:4];
    end
  end

  eth_crc32_nib u_crc (
    .crc_in (crc_q),
    .nib    (feed_nib),
    .crc_out(crc_next)
  );

  // An underrun frame carries the raw register so the receiver sees a bad FCS.
  assign fcs_nib = bad_q ? crc_q[3:0] : ~crc_q[3:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    last_d      = last_q;
    phase_d     = phase_q;
    crc_d       = crc_q;
    bad_d       = bad_q;
    txd_d       = txd_q;
    txen_d      = txen_q;
    underrun_d  = 1'b0;
    start_frame = 1'b0;
    take_byte   = 1'b0;
    go_fcs      = 1'b0;
    go_bad      = 1'b0;
`ifdef MII_TX_PAD_EN
    byte_cnt_d  = byte_cnt_q;
`endif

    case (state_q)
      IDLE: start_frame = TX_VALID;
      PRE: begin
        if (cnt_q == 8'd0) begin
          state_d = SFD;
          txd_d   = SFD_NIB;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SFD: begin
        take_byte = TX_VALID;
        go_fcs    = !TX_VALID;
        go_bad    = !TX_VALID;
      end
      DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          txd_d   = byte_q[7:4];
          crc_d   = crc_next;
        end else if (last_q) begin
`ifdef MII_TX_PAD_EN
          if (byte_cnt_q < MIN_BYTES) begin
            state_d    = PAD;
            phase_d    = 1'b0;
            txd_d      = 4'h0;
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_inc;
          end else begin
            go_fcs = 1'b1;
          end
`else
          go_fcs = 1'b1;
`endif
        end else begin
          take_byte = TX_VALID;
          go_fcs    = !TX_VALID;
          go_bad    = !TX_VALID;
        end
      end
`ifdef MII_TX_PAD_EN
      PAD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          txd_d   = 4'h0;
          crc_d   = crc_next;
        end else if (byte_cnt_q >= MIN_BYTES) begin
          go_fcs = 1'b1;
        end else begin
          phase_d    = 1'b0;
          txd_d      = 4'h0;
          crc_d      = crc_next;
          byte_cnt_d = byte_cnt_inc;
        end
      end
`endif
      FCS: begin
        if (cnt_q == 8'd0) begin
          state_d = IFG;
          cnt_d   = IFG_LOAD;
          txen_d  = 1'b0;
          txd_d   = 4'h0;
        end else begin
          cnt_d = cnt_q - 8'd1;
          txd_d = fcs_nib;
          crc_d = {4'h0, crc_q[31:4]};
        end
      end
      IFG: begin
        // Last gap edge doubles as the IDLE edge so back-to-back frames sit exactly IFG apart.
        if (cnt_q == 8'd0) begin
          state_d     = IDLE;
          start_frame = TX_VALID;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d = PRE;
      cnt_d   = PRE_LOAD;
      txd_d   = PREAMBLE_NIB;
      txen_d  = 1'b1;
      crc_d   = CRC_INIT;
      bad_d   = 1'b0;
      phase_d = 1'b0;
      last_d  = 1'b0;
    end

    if (take_byte) begin
      state_d = DATA;
      byte_d  = TX_DATA;
      last_d  = TX_LAST;
      phase_d = 1'b0;
      txd_d   = TX_DATA[3:0];
      crc_d   = crc_next;
`ifdef MII_TX_PAD_EN
      byte_cnt_d = (state_q == SFD) ? 11'd1 : byte_cnt_inc;
`endif
    end

    if (go_fcs) begin
      state_d    = FCS;
      cnt_d      = FCS_LOAD;
      bad_d      = go_bad;
      underrun_d = go_bad;
      txd_d      = go_bad ? crc_q[3:0] : ~crc_q[3:0];
      crc_d      = {4'h0, crc_q[31:4]};
    end
  end

  always_ff @(posedge RTL_TXCLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      byte_q     <= 8'd0;
      last_q     <= 1'b0;
      phase_q    <= 1'b0;
      crc_q      <= CRC_INIT;
      bad_q      <= 1'b0;
      txd_q      <= 4'h0;
      txen_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      phase_q    <= phase_d;
      crc_q      <= crc_d;
      bad_q      <= bad_d;
      txd_q      <= txd_d;
      txen_q     <= txen_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef MII_TX_PAD_EN
  always_ff @(posedge RTL_TXCLK or negedge RESETB) begin
    if (!RESETB) begin
      byte_cnt_q <= 11'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end
`endif

  assign TX_READY    = (state_q == SFD) || (state_q == DATA && phase_q && !last_q);
  assign RTL_TXD     = txd_q;
  assign RTL_TXEN    = txen_q;
  assign BUSY        = (state_q != IDLE);
  assign TX_UNDERRUN = underrun_q;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Scoreboard bench for mii_tx_framer: expected nibble streams come from a byte-level frame model.
// Honours MII_TX_PAD_EN in the model so either build can be checked.
module tb_mii_tx_framer;

  typedef logic [7:0] byte_q_t[$];

  logic       RTL_TXCLK = 1'b0;
  logic       RESETB    = 1'b0;
  logic [7:0] TX_DATA   = 8'h00;
  logic       TX_VALID  = 1'b0;
  logic       TX_LAST   = 1'b0;
  logic       TX_READY;
  logic [3:0] RTL_TXD;
  logic       RTL_TXEN;
  logic       BUSY;
  logic       TX_UNDERRUN;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_nib[$];
  int         exp_len[$];
  bit         sb_en     = 1'b0;
  int         ready_cnt = 0;
  int         urun_cnt  = 0;
  int         mon_run   = 0;

  mii_tx_framer dut (
    .RTL_TXCLK  (RTL_TXCLK),
    .RESETB     (RESETB),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_LAST    (TX_LAST),
    .TX_READY   (TX_READY),
    .RTL_TXD    (RTL_TXD),
    .RTL_TXEN   (RTL_TXEN),
    .BUSY       (BUSY),
    .TX_UNDERRUN(TX_UNDERRUN)
  );

  always #5 RTL_TXCLK = ~RTL_TXCLK;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] crc_bytes(input byte_q_t d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Frame model: drop_at>0 means only drop_at bytes are supplied before TX_VALID falls.
  task automatic expect_frame(input byte_q_t b, input int drop_at);
    byte_q_t     d;
    logic [31:0] c;
    logic [31:0] f;
    int          n0;
    int          nb;
    n0 = exp_nib.size();
    repeat (15) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    nb = (drop_at > 0) ? drop_at : b.size();
    for (int i = 0; i < nb; i++) d.push_back(b[i]);
`ifdef MII_TX_PAD_EN
    if (drop_at == 0) while (d.size() < 60) d.push_back(8'h00);
`endif
    foreach (d[i]) begin
      exp_nib.push_back(d[i][3:0]);
      exp_nib.push_back(d[i][7:4]);
    end
    c = crc_bytes(d);
    f = (drop_at > 0) ? c : ~c;
    for (int i = 0; i < 8; i++) exp_nib.push_back(f[4*i +: 4]);
    exp_len.push_back(exp_nib.size() - n0);
  endtask

  task automatic drive_frame(input byte_q_t b, input int drop_at, input bit keep,
                             input logic [7:0] nb0, input bit nl, input string tag);
    int idx;
    int cyc;
    int w;
    int consumed;
    bit rdy;
    bit done;
    idx  = 0;
    cyc  = 0;
    done = 1'b0;
    @(posedge RTL_TXCLK); #1;
    ready_cnt = 0;
    urun_cnt  = 0;
    TX_VALID  = 1'b1;
    TX_DATA   = b[0];
    TX_LAST   = (b.size() == 1);
    while (!done && cyc < 3000) begin
      @(negedge RTL_TXCLK);
      rdy = TX_READY;
      @(posedge RTL_TXCLK); #1;
      cyc++;
      if (rdy && TX_VALID) begin
        idx++;
        if (idx == b.size() || idx == drop_at) begin
          done     = 1'b1;
          TX_VALID = keep;
          TX_DATA  = keep ? nb0 : 8'h00;
          TX_LAST  = keep && nl;
        end else begin
          TX_DATA = b[idx];
          TX_LAST = (idx == b.size() - 1);
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_handshake: only %0d of %0d bytes taken before timeout", tag, idx, b.size());
      TX_VALID = 1'b0;
    end
    cyc = 0;
    while (RTL_TXEN && cyc < 1000) begin
      @(negedge RTL_TXCLK);
      cyc++;
    end
    chk({tag, "_txen_falls"}, int'(RTL_TXEN), 0);
    w = 0;
    if (keep) begin
      while (!RTL_TXEN && w < 200) begin w++; @(negedge RTL_TXCLK); end
      chk({tag, "_ifg_gap"}, w, 24);
    end else begin
      while (BUSY && w < 200) begin w++; @(negedge RTL_TXCLK); end
      chk({tag, "_busy_lag"}, w, 24);
    end
    consumed = (drop_at > 0) ? drop_at : b.size();
    chk({tag, "_ready_cycles"}, ready_cnt, consumed + ((drop_at > 0) ? 1 : 0));
    chk({tag, "_underrun_pulses"}, urun_cnt, (drop_at > 0) ? 1 : 0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge RTL_TXCLK);
      if (TX_READY) ready_cnt++;
      if (TX_UNDERRUN) urun_cnt++;
      if (!sb_en) begin
        mon_run = 0;
      end else if (RTL_TXEN) begin
        mon_run++;
        if (exp_nib.size() == 0) begin
          checks++; errors++;
          $display("FAIL txd_extra: nibble %0h with nothing expected", RTL_TXD);
        end else begin
          chk("txd", int'(RTL_TXD), int'(exp_nib.pop_front()));
        end
      end else if (mon_run > 0) begin
        if (exp_len.size() == 0) begin
          checks++; errors++;
          $display("FAIL txen_len: burst of %0d with nothing expected", mon_run);
        end else begin
          chk("txen_len", mon_run, exp_len.pop_front());
        end
        mon_run = 0;
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    byte_q_t    b;
    byte_q_t    b2;
    int         n;
    int         drop;
    logic [3:0] t1_dat[18];
    logic [3:0] t1_fcs[8];

    repeat (3) @(posedge RTL_TXCLK);
    #1;
    chk("rst_txen", int'(RTL_TXEN), 0);
    chk("rst_txd", int'(RTL_TXD), 0);
    chk("rst_ready", int'(TX_READY), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_underrun", int'(TX_UNDERRUN), 0);
    RESETB = 1'b1;
    sb_en  = 1'b1;

    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifdef MII_TX_PAD_EN
    expect_frame(b, 0);
`else
    t1_dat = '{4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h3, 4'h5,
               4'h3, 4'h6, 4'h3, 4'h7, 4'h3, 4'h8, 4'h3, 4'h9, 4'h3};
    t1_fcs = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    repeat (15) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    for (int i = 0; i < 18; i++) exp_nib.push_back(t1_dat[i]);
    for (int i = 0; i < 8; i++) exp_nib.push_back(t1_fcs[i]);
    exp_len.push_back(42);
`endif
    drive_frame(b, 0, 1'b0, 8'h00, 1'b0, "check_string");

    b = '{8'hAA};
    expect_frame(b, 0);
    drive_frame(b, 0, 1'b0, 8'h00, 1'b0, "one_byte");

    b.delete();
    repeat (64) b.push_back(8'($urandom));
    expect_frame(b, 0);
    drive_frame(b, 0, 1'b0, 8'h00, 1'b0, "len64");

    b.delete();
    b2.delete();
    repeat (5) b.push_back(8'($urandom));
    repeat (3) b2.push_back(8'($urandom));
    expect_frame(b, 0);
    expect_frame(b2, 0);
    drive_frame(b, 0, 1'b1, b2[0], 1'b0, "b2b_first");
    drive_frame(b2, 0, 1'b0, 8'h00, 1'b0, "b2b_second");

    b.delete();
    repeat (8) b.push_back(8'($urandom));
    expect_frame(b, 3);
    drive_frame(b, 3, 1'b0, 8'h00, 1'b0, "underrun");

    sb_en = 1'b0;
    @(posedge RTL_TXCLK); #1;
    TX_VALID = 1'b1;
    TX_DATA  = 8'h3C;
    TX_LAST  = 1'b0;
    repeat (24) @(posedge RTL_TXCLK);
    #3;
    chk("midrst_pre_txen", int'(RTL_TXEN), 1);
    chk("midrst_pre_busy", int'(BUSY), 1);
    RESETB = 1'b0;
    #1;
    chk("midrst_txen", int'(RTL_TXEN), 0);
    chk("midrst_txd", int'(RTL_TXD), 0);
    chk("midrst_ready", int'(TX_READY), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_underrun", int'(TX_UNDERRUN), 0);
    TX_VALID = 1'b0;
    repeat (3) @(posedge RTL_TXCLK);
    #1;
    RESETB = 1'b1;
    sb_en  = 1'b1;
    repeat (4) @(negedge RTL_TXCLK);
    chk("post_rst_idle_txen", int'(RTL_TXEN), 0);
    chk("post_rst_idle_busy", int'(BUSY), 0);
    b.delete();
    repeat (6) b.push_back(8'($urandom));
    expect_frame(b, 0);
    drive_frame(b, 0, 1'b0, 8'h00, 1'b0, "post_reset");

    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(1, 70));
      b.delete();
      repeat (n) b.push_back(8'($urandom));
      drop = 0;
      if (n >= 2 && $urandom_range(0, 3) == 0) drop = int'($urandom_range(1, n - 1));
      repeat ($urandom_range(0, 5)) @(posedge RTL_TXCLK);
      expect_frame(b, drop);
      drive_frame(b, drop, 1'b0, 8'h00, 1'b0, "random");
    end

    repeat (4) @(negedge RTL_TXCLK);
    chk("sb_nibbles_left", exp_nib.size(), 0);
    chk("sb_lengths_left", exp_len.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mii_tx_framer.md
Name: mii_tx_framer

Overview:
MII transmit framer for the RTL8201 Ethernet shield: the send side of the nibble receive path clocked by RTL_RXCLK.
- Takes a byte stream (valid/ready/last) and drives RTL_TXD/RTL_TXEN.
- Per frame it emits preamble, SFD, payload low-nibble first, optional zero padding, CRC-32 FCS, then enforces the inter-frame gap.
- Sits between a packet source (ROM/FIFO in the Marsohod2 top) and the PHY TX pins.

Parameters:
PREAMBLE_NIBBLES, 15, count of 4'h5 nibbles sent before the SFD nibble
IFG_NIBBLES, 24, idle cycles with TXEN low after the FCS (96 bit times)
MIN_PAYLOAD, 60, minimum data+pad bytes before the FCS (used only with padding compiled in)

Ports:
RTL_TXCLK  input  1  PHY TX clock (25 MHz for 100 Mb/s); the only clock
RESETB  input  1  asynchronous active-low reset
TX_DATA  input  8  payload byte
TX_VALID  input  1  TX_DATA valid
TX_LAST  input  1  qualifies TX_DATA as the final payload byte
TX_READY  output  1  byte consumed on a rising edge where TX_VALID&&TX_READY
RTL_TXD  output  4  MII TX nibble, registered
RTL_TXEN  output  1  MII TX enable, registered
BUSY  output  1  high from frame start until the end of the IFG
TX_UNDERRUN  output  1  one-cycle pulse when a byte was needed and TX_VALID was low

Behaviour:
- Clocking and reset: one clock, RTL_TXCLK; reset RESETB is asynchronous, active-low.
- While RESETB=0 (asserted at any time, including mid-frame): RTL_TXD=0, RTL_TXEN=0, TX_READY=0, BUSY=0, TX_UNDERRUN=0, state=IDLE, CRC=32'hFFFFFFFF. No partial frame resumes after release.
- IDLE → PRE: taken on the edge where TX_VALID=1. That edge sets RTL_TXEN=1, RTL_TXD=5, BUSY=1.
- PRE: output 5 for PREAMBLE_NIBBLES cycles total, then SFD.
- SFD: one cycle of 4'hD. TX_READY is high in this cycle and the first byte is accepted on its closing edge.
- DATA:
  - Phase 0 outputs byte[3:0]; phase 1 outputs byte[7:4].
  - TX_READY is high in phase 1 unless the current byte had TX_LAST.
  - If TX_READY=1 and TX_VALID=0 at that edge: underrun.
- Byte with TX_LAST: after its high nibble, go to PAD if padding is enabled and byte_count<MIN_PAYLOAD; otherwise go to FCS.
- PAD: emit zero nibbles until byte_count==MIN_PAYLOAD. Pad bytes feed the CRC.
- FCS:
  - 8 nibbles of ~CRC, bit-reflected Ethernet CRC-32 (poly 32'hEDB88320, init all-ones).
  - Order is CRC[3:0] first through CRC[31:28] last.
  - CRC covers data+pad only, not preamble or SFD.
- IFG: RTL_TXEN=0, RTL_TXD=0 for IFG_NIBBLES cycles; TX_READY=0; BUSY=1.
  - Then IDLE, with BUSY=0. A new frame may start on the very next edge.
  - TX_VALID held high across the IFG is ignored until IDLE.
- Underrun:
  - TX_UNDERRUN pulses for one cycle and nothing is consumed.
  - Jump to FCS, emitting the uncomplemented CRC register so the receiver drops the frame.
  - Then IFG as normal.
- byte_count: 11 bits, saturating at 2047. It only gates padding and no maximum length is enforced.
- Precedence when TX_VALID and TX_LAST are high on an SFD-closing edge: this is a 1-byte frame.
- TX_READY: combinational from state/phase only and never depends on TX_VALID (no loop).

Optional Feature:
MII_TX_PAD_EN:
- Defined: short frames are zero-padded to MIN_PAYLOAD bytes before the FCS.
- Undefined: the PAD state and MIN_PAYLOAD comparison are removed; FCS follows the last byte directly.
- All other timing is identical.

Decomposition:
Package mii_pkg holds:
- state enum: IDLE, PRE, SFD, DATA, PAD, FCS, IFG
- constants: PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF

Sub-module eth_crc32_nib:
- Combinational next-CRC for one 4-bit reflected input.
- Framer feeds each data/pad nibble as it is output.
- Reusable by the receive checker.

Test Plan:
1. Padding off, bytes "123456789" (31..39) → RTL_TXD sequence:
   - 15×5, D
   - 1,3,2,3,3,3,4,3,5,3,6,3,7,3,8,3,9,3
   - FCS 6,2,9,3,4,F,B,C (CRC 32'hCBF43926)
   - RTL_TXEN high exactly 42 cycles.
2. Padding on, 1-byte frame 8'hAA → A,A followed by 59 zero bytes, correct FCS; RTL_TXEN high 144 cycles; TX_READY high exactly once.
3. Padding on, 64-byte frame → no pad, 128 data nibbles, RTL_TXEN high 152 cycles.
4. Two frames with TX_VALID held → RTL_TXEN low exactly IFG_NIBBLES=24 cycles between them; second preamble intact.
5. Drop TX_VALID when byte 4 is requested → TX_UNDERRUN one pulse; FCS equals the uncomplemented CRC of bytes 1–3; IFG follows; BUSY falls 24 cycles after RTL_TXEN falls.
6. RESETB low mid-DATA → RTL_TXEN/RTL_TXD/TX_READY/BUSY go 0 without a clock edge; after release, the next frame starts with a full 15-nibble preamble.
